// File: rtl/axi_slave_write_port.sv
// -----------------------------------------------------------------------------
// axi_slave_write_port
//   Write-channel front-end of the AXI2APB bridge. The block accepts one AW
//   burst at a time and forwards each W beat to the bridge engine, together
//   with that beat's APB address. When the engine reports completion, the
//   block returns a single B response.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   aw*                         AXI write-address channel (slave side)
//   w*                          AXI write-data channel (slave side)
//   b*                          AXI write-response channel (slave side)
//   eng_accept                  engine can take a new burst
//   eng_busy                    a burst is in progress (any state but IDLE)
//   eng_beat_*                  per-beat address/data/strobe/last/handshake
//   eng_resp_valid, eng_resp    engine burst-complete pulse and response code
// -----------------------------------------------------------------------------
module axi_slave_write_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic                    eng_accept,
  output logic                    eng_busy,
  output logic [ADDR_WIDTH-1:0]   eng_beat_addr,
  output logic [DATA_WIDTH-1:0]   eng_beat_data,
  output logic [DATA_WIDTH/8-1:0] eng_beat_strb,
  output logic                    eng_beat_last,
  output logic                    eng_beat_valid,
  input  logic                    eng_beat_ready,
  input  logic                    eng_resp_valid,
  input  logic [1:0]              eng_resp
);

  localparam logic [31:0] STRB_BYTES = 32'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_W    = 2'b01,
    ST_RESP = 2'b10,
    ST_B    = 2'b11
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ID_WIDTH-1:0]     id_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [3:0]              len_r;
  logic [2:0]              size_r;
  logic [1:0]              burst_r;
  logic [3:0]              beat_cnt_r;
  logic                    proto_err_r;
  logic [1:0]              bresp_r;
  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    last_beat_s;

  // Address of the beat after 'addr'. Arithmetic wraps modulo 2^ADDR_WIDTH.
  // The INCR case aligns first, so an unaligned start address only affects
  // beat 0.
  function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [3:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wrap;
    logic [ADDR_WIDTH-1:0] nxt;
    bytes = ADDR_ONE << size;
    wrap  = ({{(ADDR_WIDTH-4){1'b0}}, len} + ADDR_ONE) * bytes;
    case (burst)
      2'b00:   nxt = addr;
      2'b10:   nxt = (addr & ~(wrap - ADDR_ONE)) | ((addr + bytes) & (wrap - ADDR_ONE));
      default: nxt = (addr & ~(bytes - ADDR_ONE)) + bytes;
    endcase
    return nxt;
  endfunction

  // Protocol violations that are detectable on the AW channel alone.
  function automatic logic aw_proto_err(
    input logic [1:0] burst,
    input logic [2:0] size,
    input logic [3:0] len
  );
    logic err;
    err = 1'b0;
    if (burst == 2'b11) begin
      err = 1'b1;
    end else if (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    if ((32'd1 << size) > STRB_BYTES) begin
      err = 1'b1;
    end else begin
      err = err;
    end
    return err;
  endfunction

  // The ready signals must be combinational so that the handshakes add no
  // latency. Holding awready low during reset makes it read 0 while rst_n
  // is asserted, even when eng_accept is high.
  assign awready        = rst_n && (state_r == ST_IDLE) && eng_accept;
  assign wready         = (state_r == ST_W) && eng_beat_ready;
  assign eng_beat_valid = (state_r == ST_W) && wvalid;
  assign eng_beat_last  = (state_r == ST_W) && last_beat_s;
  assign eng_beat_addr  = addr_r;
  assign eng_beat_data  = wdata;
  assign eng_beat_strb  = wstrb;
  assign eng_busy       = (state_r != ST_IDLE);
  assign bvalid         = (state_r == ST_B);
  assign bid            = id_r;
  assign bresp          = bresp_r;

  assign aw_hs_s     = awvalid && awready;
  assign w_hs_s      = wvalid && wready;
  assign last_beat_s = (beat_cnt_r == len_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. The burst always ends on the beat count, never on wlast.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (aw_hs_s) state_nxt_s = ST_W;
        else         state_nxt_s = ST_IDLE;
      end
      ST_W: begin
        if (w_hs_s && last_beat_s) state_nxt_s = ST_RESP;
        else                       state_nxt_s = ST_W;
      end
      ST_RESP: begin
        if (eng_resp_valid) state_nxt_s = ST_B;
        else                state_nxt_s = ST_RESP;
      end
      ST_B: begin
        if (bready) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_B;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Burst context, beat tracking, error accumulation and the response latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r        <= '0;
      addr_r      <= '0;
      len_r       <= 4'd0;
      size_r      <= 3'd0;
      burst_r     <= 2'b00;
      beat_cnt_r  <= 4'd0;
      proto_err_r <= 1'b0;
      bresp_r     <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (aw_hs_s) begin
            id_r        <= awid;
            addr_r      <= awaddr;
            len_r       <= awlen;
            size_r      <= awsize;
            // The reserved burst encoding is handled as INCR.
            burst_r     <= (awburst == 2'b11) ? 2'b01 : awburst;
            beat_cnt_r  <= 4'd0;
            proto_err_r <= aw_proto_err(awburst, awsize, awlen);
          end
        end
        ST_W: begin
          if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
            addr_r     <= next_beat_addr(addr_r, size_r, len_r, burst_r);
            if (wlast != last_beat_s) begin
              proto_err_r <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (eng_resp_valid) begin
            // A protocol error overrides the engine's code, except that a
            // DECERR from the engine is preserved.
            if (proto_err_r) begin
              bresp_r <= (eng_resp == 2'b11) ? 2'b11 : 2'b10;
            end else begin
              bresp_r <= eng_resp;
            end
          end
        end
        default: begin
          bresp_r <= bresp_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_write_port.sv
module tb_axi_slave_write_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        eng_accept;
  logic        eng_busy;
  logic [31:0] eng_beat_addr;
  logic [31:0] eng_beat_data;
  logic [3:0]  eng_beat_strb;
  logic        eng_beat_last;
  logic        eng_beat_valid;
  logic        eng_beat_ready;
  logic        eng_resp_valid;
  logic [1:0]  eng_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_slave_write_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .eng_accept(eng_accept), .eng_busy(eng_busy),
    .eng_beat_addr(eng_beat_addr), .eng_beat_data(eng_beat_data), .eng_beat_strb(eng_beat_strb),
    .eng_beat_last(eng_beat_last), .eng_beat_valid(eng_beat_valid), .eng_beat_ready(eng_beat_ready),
    .eng_resp_valid(eng_resp_valid), .eng_resp(eng_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference beat-address sequence: FIXED holds; INCR steps to the next
  // aligned slot; WRAP stays inside the (len+1)*bytes window at its base.
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] size,
                                             input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] b, w, lo;
    b = 32'd1 << size;
    w = (32'(len) + 32'd1) * b;
    case (burst)
      2'b00: return a;
      2'b10: begin
        lo = (a / w) * w;
        return lo + ((a - lo + b) % w);
      end
      default: return (a / b) * b + b;
    endcase
  endfunction

  function automatic logic [1:0] model_bresp(input logic [1:0] burst, input logic [2:0] size,
                                             input logic [3:0] len, input bit wlast_err,
                                             input logic [1:0] code);
    bit proto;
    proto = (burst == 2'b11) || ((32'd1 << size) > 32'd4) || wlast_err ||
            (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    if (proto) return (code == 2'b11) ? 2'b11 : 2'b10;
    else       return code;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic send_aw(input logic id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int waits);
    waits = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    #1;
    while (!awready && waits < 50) begin
      @(posedge clk); @(negedge clk); #1;
      waits++;
    end
    if (!awready) chk("aw_timeout", 64'(awready), 64'(1));
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nb, input int err_beat,
                            input int unsigned stall);
    logic [31:0] cur;
    logic [1:0]  mb;
    int i, cyc;
    bit r, v;
    cur = addr; i = 0; cyc = 0;
    mb = (burst == 2'b11) ? 2'b01 : burst;
    while (i < nb && cyc < nb * 40 + 40) begin
      r = ($urandom_range(99) >= stall);
      v = ($urandom_range(99) >= stall);
      eng_beat_ready = r; wvalid = v;
      wdata = $urandom; wstrb = 4'($urandom_range(15));
      wlast = (i == int'(len)) ^ (i == err_beat);
      eng_resp_valid = 1'($urandom_range(1)); eng_resp = 2'($urandom_range(3));
      #1;
      chk("wready", 64'(wready), 64'(r));
      chk("beat_valid", 64'(eng_beat_valid), 64'(v));
      chk("beat_addr", 64'(eng_beat_addr), 64'(cur));
      chk("beat_last", 64'(eng_beat_last), 64'(i == int'(len)));
      chk("beat_data", 64'(eng_beat_data), 64'(wdata));
      chk("beat_strb", 64'(eng_beat_strb), 64'(wstrb));
      chk("busy_w", 64'(eng_busy), 64'(1));
      chk("awready_w", 64'(awready), 64'(0));
      if (r && v) begin
        i++;
        cur = model_next(cur, size, len, mb);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (i < nb) chk("beat_timeout", 64'(i), 64'(nb));
    wvalid = 1'b0; eng_beat_ready = 1'b0; eng_resp_valid = 1'b0; wlast = 1'b0;
  endtask

  task automatic resp_phase(input logic [1:0] code, input int delay);
    for (int k = 0; k <= delay; k++) begin
      wvalid = 1'b1; eng_beat_ready = 1'b1;
      eng_resp_valid = (k == delay);
      eng_resp = (k == delay) ? code : 2'($urandom_range(3));
      #1;
      chk("wready_resp", 64'(wready), 64'(0));
      chk("beat_valid_resp", 64'(eng_beat_valid), 64'(0));
      chk("bvalid_resp", 64'(bvalid), 64'(0));
      chk("awready_resp", 64'(awready), 64'(0));
      chk("busy_resp", 64'(eng_busy), 64'(1));
      @(posedge clk); @(negedge clk);
    end
    eng_resp_valid = 1'b0; wvalid = 1'b0; eng_beat_ready = 1'b0;
  endtask

  task automatic b_phase(input logic id, input logic [1:0] exp_resp, input int hold);
    for (int k = 0; k <= hold; k++) begin
      bready = (k == hold);
      eng_resp_valid = 1'b1; eng_resp = ~exp_resp;
      wvalid = 1'b1; eng_beat_ready = 1'b1;
      #1;
      chk("bvalid", 64'(bvalid), 64'(1));
      chk("bid", 64'(bid), 64'(id));
      chk("bresp", 64'(bresp), 64'(exp_resp));
      chk("awready_b", 64'(awready), 64'(0));
      chk("wready_b", 64'(wready), 64'(0));
      @(posedge clk); @(negedge clk);
    end
    bready = 1'b0; eng_resp_valid = 1'b0; wvalid = 1'b0; eng_beat_ready = 1'b0;
    #1;
    chk("bvalid_done", 64'(bvalid), 64'(0));
    chk("busy_done", 64'(eng_busy), 64'(0));
    chk("awready_idle", 64'(awready), 64'(1));
  endtask

  task automatic run_burst(input logic id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int err_beat,
                           input logic [1:0] code, input int unsigned stall, input int delay,
                           input int hold);
    int waits;
    send_aw(id, addr, len, size, burst, waits);
    chk("aw_wait", 64'(waits), 64'(0));
    send_beats(addr, len, size, burst, int'(len) + 1, err_beat, stall);
    resp_phase(code, delay);
    b_phase(id, model_bresp(burst, size, len, err_beat >= 0, code), hold);
  endtask

  initial begin
    int waits;
    logic [1:0] rb, rc;
    logic [2:0] rs;
    logic [3:0] rl;
    int eb;

    rst_n = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; eng_accept = 1'b1;
    eng_beat_ready = 1'b0; eng_resp_valid = 1'b0; eng_resp = 2'b00;

    @(negedge clk); #1;
    chk("rst_awready", 64'(awready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_busy", 64'(eng_busy), 64'(0));
    chk("rst_addr", 64'(eng_beat_addr), 64'(0));
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed bursts.
    run_burst(1'b1, 32'h100, 4'd0, 3'd2, 2'b01, -1, 2'b00, 0, 0, 0);
    run_burst(1'b0, 32'h102, 4'd3, 3'd2, 2'b01, -1, 2'b00, 30, 1, 0);
    run_burst(1'b1, 32'h38,  4'd3, 3'd2, 2'b10, -1, 2'b00, 20, 0, 1);
    run_burst(1'b0, 32'h20,  4'd2, 3'd2, 2'b00, -1, 2'b00, 20, 2, 0);
    run_burst(1'b1, 32'h80,  4'd2, 3'd2, 2'b01, 1,  2'b00, 0, 0, 0);
    run_burst(1'b0, 32'h80,  4'd2, 3'd2, 2'b01, 1,  2'b11, 0, 0, 0);
    run_burst(1'b0, 32'h40,  4'd1, 3'd2, 2'b11, -1, 2'b00, 0, 0, 0);
    run_burst(1'b1, 32'h40,  4'd1, 3'd3, 2'b01, -1, 2'b00, 0, 0, 0);

    // Reset during beat 2 of 4 (previous B left bid=1, bresp=10).
    send_aw(1'b1, 32'h200, 4'd3, 3'd2, 2'b01, waits);
    send_beats(32'h200, 4'd3, 3'd2, 2'b01, 2, -1, 0);
    wvalid = 1'b1; eng_beat_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid_rst_awready", 64'(awready), 64'(0));
    chk("mid_rst_wready", 64'(wready), 64'(0));
    chk("mid_rst_bvalid", 64'(bvalid), 64'(0));
    chk("mid_rst_bid", 64'(bid), 64'(0));
    chk("mid_rst_bresp", 64'(bresp), 64'(0));
    chk("mid_rst_beat_valid", 64'(eng_beat_valid), 64'(0));
    chk("mid_rst_beat_last", 64'(eng_beat_last), 64'(0));
    chk("mid_rst_busy", 64'(eng_busy), 64'(0));
    chk("mid_rst_addr", 64'(eng_beat_addr), 64'(0));
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; wvalid = 1'b0; eng_beat_ready = 1'b0;
    #1;
    chk("post_rst_awready", 64'(awready), 64'(1));
    run_burst(1'b0, 32'h300, 4'd0, 3'd2, 2'b01, -1, 2'b00, 0, 0, 0);

    // eng_accept low: AW held but never taken.
    eng_accept = 1'b0;
    awid = 1'b1; awaddr = 32'h3F0; awlen = 4'd5; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("noacc_awready", 64'(awready), 64'(0));
      chk("noacc_busy", 64'(eng_busy), 64'(0));
      @(posedge clk); @(negedge clk);
    end
    awvalid = 1'b0; eng_accept = 1'b1;
    run_burst(1'b1, 32'h400, 4'd0, 3'd2, 2'b01, -1, 2'b10, 0, 0, 0);

    // bready held low 5 cycles with the next AW already pending.
    send_aw(1'b0, 32'h40, 4'd1, 3'd2, 2'b01, waits);
    send_beats(32'h40, 4'd1, 3'd2, 2'b01, 2, -1, 0);
    resp_phase(2'b00, 1);
    awid = 1'b1; awaddr = 32'h500; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    b_phase(1'b0, 2'b00, 5);
    send_aw(1'b1, 32'h500, 4'd0, 3'd2, 2'b01, waits);
    chk("aw_after_b", 64'(waits), 64'(0));
    send_beats(32'h500, 4'd0, 3'd2, 2'b01, 1, -1, 0);
    resp_phase(2'b00, 0);
    b_phase(1'b1, 2'b00, 0);

    // Randomized bursts against the reference model.
    for (int n = 0; n < 40; n++) begin
      rb = 2'($urandom_range(3));
      rs = ($urandom_range(4) == 0) ? 3'd3 : 3'($urandom_range(2));
      if (rb == 2'b10) begin
        case ($urandom_range(3))
          0: rl = 4'd1;
          1: rl = 4'd3;
          2: rl = 4'd7;
          default: rl = 4'd15;
        endcase
      end else begin
        rl = 4'($urandom_range(15));
      end
      eb = ($urandom_range(4) == 0) ? int'($urandom_range(int'(rl))) : -1;
      rc = 2'($urandom_range(3));
      run_burst(1'($urandom_range(1)), $urandom, rl, rs, rb, eb, rc, 30,
                int'($urandom_range(3)), int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
